// File: rtl/alu_uart_host.sv
// alu_uart_host: host-side initiator that sends (a, b, op) over a UART FIFO pair and returns the result byte
// Ports: clk/reset (async, active-high); cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_op command in;
//        rsp_valid/rsp_ready/rsp_data/rsp_timeout response out; wr_uart/w_data/tx_full TX FIFO push;
//        rd_uart/r_data/rx_empty RX FIFO pop.
// Optional: define ALU_HOST_TIMEOUT_EN to build the TIMEOUT_CYCLES response-wait limit.
module alu_uart_host #(
  parameter int REG_SIZE       = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [REG_SIZE-1:0] cmd_a,
  input  logic [REG_SIZE-1:0] cmd_b,
  input  logic [REG_SIZE-1:0] cmd_op,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [REG_SIZE-1:0] rsp_data,
  output logic                rsp_timeout,
  output logic                wr_uart,
  output logic [7:0]          w_data,
  input  logic                tx_full,
  output logic                rd_uart,
  input  logic [7:0]          r_data,
  input  logic                rx_empty
);
  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, SEND_OP, WAIT_RSP, RESP} state_t;
  state_t state;
  logic [REG_SIZE-1:0] a_q, b_q, op_q;
  logic expired;
  if (REG_SIZE != 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("alu_uart_host: REG_SIZE must be 8 and TIMEOUT_CYCLES >= 2");
  end
  always_comb begin
    cmd_ready = !reset && state == IDLE;
    rsp_valid = state == RESP;
    wr_uart   = !tx_full && (state == SEND_A || state == SEND_B || state == SEND_OP);
    rd_uart   = !reset && !rx_empty && (state == IDLE || state == WAIT_RSP);
    w_data    = state == SEND_A ? a_q : state == SEND_B ? b_q : state == SEND_OP ? op_q : '0;
  end
`ifdef ALU_HOST_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt;
  assign expired = cnt == CW'(TIMEOUT_CYCLES - 1);
  // Counter idles at zero outside WAIT_RSP, so it is clear on every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      cnt <= (state == WAIT_RSP && rx_empty) ? cnt + 1'b1 : '0;
      if (state == WAIT_RSP && (!rx_empty || expired)) rsp_timeout <= rx_empty;
    end
  end
`else
  assign expired     = 1'b0;
  assign rsp_timeout = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      rsp_data <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          a_q   <= cmd_a;
          b_q   <= cmd_b;
          op_q  <= cmd_op;
          state <= SEND_A;
        end
        SEND_A:  if (!tx_full) state <= SEND_B;
        SEND_B:  if (!tx_full) state <= SEND_OP;
        SEND_OP: if (!tx_full) state <= WAIT_RSP;
        // A byte arriving in the expiry cycle wins over the timeout.
        WAIT_RSP: if (!rx_empty || expired) begin
          rsp_data <= rx_empty ? '0 : r_data;
          state    <= RESP;
        end
        RESP:    if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_uart_host.sv
// tb_alu_uart_host: randomized scoreboard bench with FIFO and remote-ALU models for alu_uart_host
module tb_alu_uart_host;
  localparam int TO = 16;
  logic clk = 0, reset = 1;
  logic cmd_valid = 0, cmd_ready;
  logic [7:0] cmd_a = 0, cmd_b = 0, cmd_op = 0;
  logic rsp_valid, rsp_ready = 1, rsp_timeout, wr_uart, rd_uart;
  logic [7:0] rsp_data, w_data, r_data = 0;
  logic tx_full = 0, rx_empty = 1;
  typedef struct {logic [7:0] d; int t;} pend_t;
  typedef struct {logic [7:0] d; logic to;} rsp_t;
  logic [7:0] rx_q[$], exp_tx[$], tx_cap[$];
  pend_t pend[$];
  rsp_t exp_rsp[$];
  int push_cyc[$];
  int cyc = 0, acc_cnt = 0, acc_cyc = 0, rsp_cnt = 0, rsp_first = 0, pop_cyc = 0, n_cmp = 0, n_err = 0;
  bit alu_on = 1, force_full = 0, rand_full = 0, hold_ready = 0, rand_ready = 0;
  int alu_dly_max = 0;
  logic prev_valid = 0, prev_to = 0;
  logic [7:0] prev_data = 0;

  always #5 clk = ~clk;

  alu_uart_host #(.REG_SIZE(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .wr_uart(wr_uart), .w_data(w_data), .tx_full(tx_full), .rd_uart(rd_uart),
    .r_data(r_data), .rx_empty(rx_empty));

  // Remote ALU behaviour: what the far end computes from the three bytes it receives.
  function automatic logic [7:0] alu_ref(input logic [7:0] a, b, op);
    case (op)
      8'h20:   return a + b;
      8'h22:   return a - b;
      8'h24:   return a & b;
      8'h25:   return a | b;
      default: return a ^ b ^ op;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Each cycle: stimulus changes at the falling edge, FIFO inputs at +1, outputs sampled at +2.
  always @(negedge clk) begin
    pend_t p;
    rsp_t e;
    #1;
    cyc++;
    while (pend.size() > 0 && pend[0].t <= cyc) begin
      p = pend.pop_front();
      rx_q.push_back(p.d);
    end
    rx_empty  = rx_q.size() == 0;
    r_data    = rx_empty ? 8'h00 : rx_q[0];
    tx_full   = force_full || (rand_full && $urandom_range(3) == 0);
    rsp_ready = !hold_ready && (!rand_ready || $urandom_range(3) != 0);
    #1;
    if (wr_uart) begin
      chk("push_while_full", tx_full, 0);
      chk("rd_wr_overlap", rd_uart, 0);
      if (exp_tx.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_push: got %0h expected no push (cycle %0d)", w_data, cyc);
      end else chk("tx_byte", w_data, exp_tx.pop_front());
      tx_cap.push_back(w_data);
      push_cyc.push_back(cyc);
      if (tx_cap.size() == 3) begin
        if (alu_on) pend.push_back('{alu_ref(tx_cap[0], tx_cap[1], tx_cap[2]), cyc + 1 + int'($urandom_range(alu_dly_max))});
        tx_cap.delete();
      end
    end else if (tx_full && !reset && !cmd_ready && exp_tx.size() > 0) chk("stall_w_data", w_data, exp_tx[0]);
    if (rd_uart) begin
      chk("pop_while_empty", rx_empty, 0);
      chk("pop_in_resp", rsp_valid, 0);
      if (rx_q.size() > 0) void'(rx_q.pop_front());
      pop_cyc = cyc;
    end
    if (cmd_valid && cmd_ready) begin
      acc_cnt++;
      acc_cyc = cyc;
      push_cyc.delete();
    end
    if (rsp_valid) begin
      chk("cmd_ready_in_resp", cmd_ready, 0);
      if (!prev_valid) rsp_first = cyc;
      else begin
        chk("rsp_data_stable", rsp_data, prev_data);
        chk("rsp_timeout_stable", rsp_timeout, prev_to);
      end
      if (rsp_ready) begin
        rsp_cnt++;
        if (exp_rsp.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_rsp: got %0h expected no response (cycle %0d)", rsp_data, cyc);
        end else begin
          e = exp_rsp.pop_front();
          chk("rsp_data", rsp_data, e.d);
          chk("rsp_timeout", rsp_timeout, e.to);
        end
      end
    end
    prev_valid = rsp_valid && !rsp_ready;
    prev_data  = rsp_data;
    prev_to    = rsp_timeout;
  end

  task automatic issue(input logic [7:0] a, b, op);
    int start = acc_cnt;
    int g = 0;
    rsp_t r;
    exp_tx.push_back(a);
    exp_tx.push_back(b);
    exp_tx.push_back(op);
    r.d  = alu_on ? alu_ref(a, b, op) : 8'h00;
    r.to = !alu_on;
    exp_rsp.push_back(r);
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    cmd_valid = 1;
    do begin
      @(negedge clk);
      g++;
    end while (acc_cnt == start && g < 100);
    if (acc_cnt == start) chk("accept_wait", acc_cnt, start + 1);
    cmd_valid = 0;
    cmd_a = 8'($urandom);
    cmd_b = 8'($urandom);
    cmd_op = 8'($urandom);
  endtask

  task automatic wait_rsp(input int tgt, input int lim);
    int g = 0;
    while (rsp_cnt < tgt && g < lim) begin
      @(negedge clk);
      g++;
    end
    if (rsp_cnt < tgt) chk("rsp_wait", rsp_cnt, tgt);
  endtask

  task automatic wait_first_push();
    int g = 0;
    while (push_cyc.size() < 1 && g < 50) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic flush_model();
    exp_tx.delete();
    exp_rsp.delete();
    tx_cap.delete();
    pend.delete();
  endtask

  initial begin
    int tgt;
    int k;
    logic [7:0] ops[5];
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h3C};
    rx_q.push_back(8'h77);
    repeat (2) @(negedge clk);
    #3;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_timeout", rsp_timeout, 0);
    chk("reset_wr_uart", wr_uart, 0);
    chk("reset_rd_uart", rd_uart, 0);
    chk("reset_w_data", w_data, 0);
    @(negedge clk);
    reset = 0;
    #3;
    chk("cmd_ready_after_reset", cmd_ready, 1);
    chk("idle_flush_rd", rd_uart, 1);
    repeat (3) @(negedge clk);

    tgt = rsp_cnt + 1;
    issue(8'h05, 8'h03, 8'h20);
    wait_rsp(tgt, 50);
    k = acc_cyc;
    chk("basic_push_count", push_cyc.size(), 3);
    if (push_cyc.size() == 3) begin
      chk("basic_push_a_cyc", push_cyc[0], k + 1);
      chk("basic_push_b_cyc", push_cyc[1], k + 2);
      chk("basic_push_op_cyc", push_cyc[2], k + 3);
    end
    chk("basic_pop_cyc", pop_cyc, k + 4);
    chk("basic_rsp_cyc", rsp_first, k + 5);

    tgt = rsp_cnt + 1;
    issue(8'h9A, 8'h4C, 8'h22);
    wait_first_push();
    force_full = 1;
    repeat (4) @(negedge clk);
    force_full = 0;
    wait_rsp(tgt, 50);
    chk("stall_push_count", push_cyc.size(), 3);
    if (push_cyc.size() == 3) chk("stall_b_gap", push_cyc[1] - push_cyc[0], 5);

    tgt = rsp_cnt + 1;
    hold_ready = 1;
    issue(8'hFF, 8'hFF, 8'h20);
    k = 0;
    while (!prev_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    rx_q.push_back(8'h5A);
    repeat (3) @(negedge clk);
    hold_ready = 0;
    wait_rsp(tgt, 20);
    repeat (3) @(negedge clk);
    chk("resp_stale_flushed", rx_q.size(), 0);

    rx_q.push_back(8'($urandom));
    rx_q.push_back(8'($urandom));
    repeat (4) @(negedge clk);
    chk("stale_flushed", rx_q.size(), 0);
    tgt = rsp_cnt + 1;
    issue(8'h21, 8'h12, 8'h24);
    wait_rsp(tgt, 50);

    alu_on = 0;
`ifdef ALU_HOST_TIMEOUT_EN
    tgt = rsp_cnt + 1;
    issue(8'h11, 8'h22, 8'h20);
    wait_rsp(tgt, 100);
    if (push_cyc.size() == 3) chk("timeout_latency", rsp_first - (push_cyc[2] + 1), TO);
`else
    issue(8'h11, 8'h22, 8'h20);
    exp_rsp.delete();
    repeat (40) begin
      @(negedge clk);
      #3;
      chk("no_rsp_without_timeout", rsp_valid, 0);
    end
    reset = 1;
    @(negedge clk);
    reset = 0;
    flush_model();
`endif
    alu_on = 1;
    repeat (2) @(negedge clk);

    issue(8'h44, 8'h33, 8'h25);
    wait_first_push();
    force_full = 1;
    repeat (2) @(negedge clk);
    reset = 1;
    force_full = 0;
    #3;
    chk("abort_wr_uart", wr_uart, 0);
    chk("abort_rd_uart", rd_uart, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_w_data", w_data, 0);
    flush_model();
    @(negedge clk);
    reset = 0;
    #3;
    chk("abort_cmd_ready", cmd_ready, 1);
    repeat (10) @(negedge clk);

    rand_full = 1;
    rand_ready = 1;
    alu_dly_max = 3;
    repeat (40) begin
      tgt = rsp_cnt + 1;
      issue(8'($urandom), 8'($urandom), ops[$urandom_range(4)]);
      wait_rsp(tgt, 200);
    end
    rand_full = 0;
    rand_ready = 0;
    repeat (5) @(negedge clk);
    chk("tx_scoreboard_empty", exp_tx.size(), 0);
    chk("rsp_scoreboard_empty", exp_rsp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
